gumnut_ctrl_fsm: RTL and testbench

Parametrised multi-cycle control FSM for the Gumnut core, successor to the fixed single-interrupt controller. It sequences fetch, decode, execute, memory/IO, write-back and interrupt entry for 18-bit Gumnut instructions. It also adds:
- multiple prioritised interrupt sources;
- internal interrupt-enable tracking (enai/disi/reti);
- a sleep state for the wait/stby instructions;
- a bus-timeout halt.

It sits between the instruction register and the datapath/bus interfaces.

---
 rtl/gumnut_ctrl_if.sv | 36 +++
 rtl/gumnut_ctrl_fsm.sv | 146 ++++++++++++++
 tb/tb_gumnut_ctrl_fsm.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gumnut_ctrl_if.sv
// Handshake and bus bundle between the Gumnut control FSM and the rest of the core.
// master: the controller side; slave: the instruction register, datapath and bus side.
interface gumnut_ctrl_if #(
    parameter int unsigned IRQ_N = 4
);
    localparam int unsigned VEC_W = (IRQ_N > 1) ? $clog2(IRQ_N) : 1;

    logic [17:0]      IR;
    logic [IRQ_N-1:0] int_req_i;
    logic             inst_ack_i;
    logic             data_ack_i;
    logic             port_ack_i;
    logic             inst_stb_o;
    logic             data_stb_o;
    logic             data_we_o;
    logic             port_stb_o;
    logic             port_we_o;
    logic             reg_we_o;
    logic             int_ack_o;
    logic [VEC_W-1:0] int_vec_o;
    logic             int_en_o;
    logic             bus_err_o;
    logic [2:0]       state;

    modport master (
        input  IR, int_req_i, inst_ack_i, data_ack_i, port_ack_i,
        output inst_stb_o, data_stb_o, data_we_o, port_stb_o, port_we_o, reg_we_o,
               int_ack_o, int_vec_o, int_en_o, bus_err_o, state
    );

    modport slave (
        output IR, int_req_i, inst_ack_i, data_ack_i, port_ack_i,
        input  inst_stb_o, data_stb_o, data_we_o, port_stb_o, port_we_o, reg_we_o,
               int_ack_o, int_vec_o, int_en_o, bus_err_o, state
    );
endinterface

// File: rtl/gumnut_ctrl_fsm.sv
// Multi-cycle Gumnut control FSM: fetch/decode/execute/mem/write-back sequencing with
// prioritised interrupts, sleep on wait/stby and a bus-timeout halt.
module gumnut_ctrl_fsm #(
    parameter int unsigned IRQ_N   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    gumnut_ctrl_if.master bus
);
    localparam int unsigned VEC_W = (IRQ_N > 1) ? $clog2(IRQ_N) : 1;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StInt    = 3'd5,
        StSleep  = 3'd6,
        StHalt   = 3'd7
    } state_e;

    state_e           state_q, state_d, ret_state;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             int_en_q, int_en_d;
    logic             saved_q, saved_d;
    logic [VEC_W-1:0] vec_next;
    logic             timeout_hit, mem_ack, any_req;
    logic             is_mem, is_alu, is_misc;
    logic [2:0]       misc_fn;

    logic             inst_stb_q, data_stb_q, data_we_q, port_stb_q, port_we_q;
    logic             reg_we_q, int_ack_q, bus_err_q;
    logic [VEC_W-1:0] int_vec_q;

    assign is_mem  = (bus.IR[17:16] == 2'b10);
    assign is_alu  = ~bus.IR[17] | (bus.IR[17:15] == 3'b110) | (bus.IR[17:14] == 4'b1110);
    assign is_misc = (bus.IR[17:11] == 7'b1111110);
    assign misc_fn = bus.IR[10:8];

    // IR[15] selects IO over data memory; IR[14] marks the write forms (stm/out).
    assign mem_ack     = bus.IR[15] ? bus.port_ack_i : bus.data_ack_i;
    assign any_req     = |bus.int_req_i;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign ret_state   = (int_en_q && any_req) ? StInt : StFetch;

    always_comb begin
        vec_next = '0;
        for (int i = int'(IRQ_N) - 1; i >= 0; i--) begin
            if (bus.int_req_i[i]) vec_next = VEC_W'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        int_en_d = int_en_q;
        saved_d  = saved_q;
        case (state_q)
            StFetch: begin
                if (bus.inst_ack_i)   state_d = StDecode;
                else if (timeout_hit) state_d = StHalt;
                else                  cnt_d = cnt_q + CNT_W'(1);
            end
            StDecode: state_d = is_mem ? StMem : StExec;
            StExec: begin
                if (is_alu) begin
                    state_d = StWb;
                end else if (is_misc) begin
                    state_d = ret_state;
                    case (misc_fn)
                        3'b001:         int_en_d = saved_q;
                        3'b010:         int_en_d = 1'b1;
                        3'b011:         int_en_d = 1'b0;
                        3'b100, 3'b101: state_d = StSleep;
                        default:        ;
                    endcase
                end else begin
                    state_d = ret_state;
                end
            end
            StMem: begin
                if (mem_ack)          state_d = bus.IR[14] ? ret_state : StWb;
                else if (timeout_hit) state_d = StHalt;
                else                  cnt_d = cnt_q + CNT_W'(1);
            end
            StWb:    state_d = ret_state;
            StInt:   state_d = StFetch;
            StSleep: if (any_req) state_d = int_en_q ? StInt : StFetch;
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
        // Interrupt entry masks further interrupts; reti brings the enable back.
        if (state_d == StInt) begin
            int_en_d = 1'b0;
            saved_d  = 1'b1;
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= StFetch;
            cnt_q      <= '0;
            int_en_q   <= 1'b0;
            saved_q    <= 1'b0;
            inst_stb_q <= 1'b0;
            data_stb_q <= 1'b0;
            data_we_q  <= 1'b0;
            port_stb_q <= 1'b0;
            port_we_q  <= 1'b0;
            reg_we_q   <= 1'b0;
            int_ack_q  <= 1'b0;
            int_vec_q  <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            int_en_q   <= int_en_d;
            saved_q    <= saved_d;
            inst_stb_q <= (state_d == StFetch);
            data_stb_q <= (state_d == StMem) && !bus.IR[15];
            data_we_q  <= (state_d == StMem) && !bus.IR[15] && bus.IR[14];
            port_stb_q <= (state_d == StMem) && bus.IR[15];
            port_we_q  <= (state_d == StMem) && bus.IR[15] && bus.IR[14];
            reg_we_q   <= (state_d == StWb);
            int_ack_q  <= (state_d == StInt);
            if (state_d == StInt) int_vec_q <= vec_next;
            bus_err_q  <= bus_err_q | (state_d == StHalt);
        end
    end

    assign bus.state      = state_q;
    assign bus.inst_stb_o = inst_stb_q;
    assign bus.data_stb_o = data_stb_q;
    assign bus.data_we_o  = data_we_q;
    assign bus.port_stb_o = port_stb_q;
    assign bus.port_we_o  = port_we_q;
    assign bus.reg_we_o   = reg_we_q;
    assign bus.int_ack_o  = int_ack_q;
    assign bus.int_vec_o  = int_vec_q;
    assign bus.int_en_o   = int_en_q;
    assign bus.bus_err_o  = bus_err_q;
endmodule

// File: tb/tb_gumnut_ctrl_fsm.sv
// Directed bench for gumnut_ctrl_fsm: one DUT with the default timeout, one with TIMEOUT=4.
module tb_gumnut_ctrl_fsm;
    localparam logic [17:0] IR_ALU  = 18'b111000000000000001;
    localparam logic [17:0] IR_BR   = 18'b111100000000000000;
    localparam logic [17:0] IR_LDM  = 18'b100000100000000000;
    localparam logic [17:0] IR_STM  = 18'b100100000000000000;
    localparam logic [17:0] IR_INP  = 18'b101000000000000000;
    localparam logic [17:0] IR_OUT  = 18'b101100000000000000;
    localparam logic [17:0] IR_RETI = 18'b111111000100000000;
    localparam logic [17:0] IR_ENAI = 18'b111111001000000000;
    localparam logic [17:0] IR_DISI = 18'b111111001100000000;
    localparam logic [17:0] IR_WAIT = 18'b111111010000000000;
    localparam logic [17:0] IR_STBY = 18'b111111010100000000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    gumnut_ctrl_if #(.IRQ_N(4)) bus ();
    gumnut_ctrl_if #(.IRQ_N(4)) bus_to ();

    gumnut_ctrl_fsm #(.IRQ_N(4), .TIMEOUT(16)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    gumnut_ctrl_fsm #(.IRQ_N(4), .TIMEOUT(4)) dut_to (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus_to)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [14:0] outs;
        bus.IR = IR_ALU; bus.int_req_i = '0;
        bus.inst_ack_i = 1'b1; bus.data_ack_i = 1'b0; bus.port_ack_i = 1'b0;
        bus_to.IR = IR_ALU; bus_to.int_req_i = '0;
        bus_to.inst_ack_i = 1'b1; bus_to.data_ack_i = 1'b0; bus_to.port_ack_i = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        outs = {bus.inst_stb_o, bus.data_stb_o, bus.data_we_o, bus.port_stb_o, bus.port_we_o,
                bus.reg_we_o, bus.int_ack_o, bus.int_vec_o, bus.int_en_o, bus.bus_err_o,
                bus.state};
        n_tests++;
        if (outs !== 15'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %b want 0", outs);
        end
        n_tests++;
        if (bus_to.state !== 3'd0 || bus_to.bus_err_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_to_state: got %0d/%b want 0/0",
                                bus_to.state, bus_to.bus_err_o);
        end
        rst_n = 1'b1;
        tick();
        tick();
        n_tests++;
        if (bus.state !== 3'd2) begin
            n_fail++; $display("FAIL reset_pre_async: got %0d want 2", bus.state);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.state !== 3'd0) begin
            n_fail++; $display("FAIL reset_async: got %0d want 0", bus.state);
        end
        tick();
    endtask

    task automatic test_alu();
        logic [2:0] seq [4];
        int         pulses;
        seq = '{3'd1, 3'd2, 3'd4, 3'd0};
        pulses = 0;
        bus.IR = IR_ALU; bus.inst_ack_i = 1'b1;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.reg_we_o === 1'b1) pulses++;
            n_tests++;
            if (bus.state !== seq[i % 4] || bus.reg_we_o !== (seq[i % 4] == 3'd4)) begin
                n_fail++; $display("FAIL alu_seq[%0d]: got state %0d we %b want state %0d",
                                    i, bus.state, bus.reg_we_o, seq[i % 4]);
            end
        end
        n_tests++;
        if (pulses != 2) begin
            n_fail++; $display("FAIL alu_reg_we_pulses: got %0d want 2", pulses);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] seq [3];
        seq = '{3'd1, 3'd2, 3'd0};
        bus.IR = IR_BR; bus.inst_ack_i = 1'b1;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            n_tests++;
            if (bus.state !== seq[i % 3] || bus.reg_we_o !== 1'b0) begin
                n_fail++; $display("FAIL branch_seq[%0d]: got %0d we %b want %0d we 0",
                                    i, bus.state, bus.reg_we_o, seq[i % 3]);
            end
        end
    endtask

    task automatic test_mem_wait();
        bus.IR = IR_LDM; bus.inst_ack_i = 1'b1; bus.data_ack_i = 1'b0; bus.port_ack_i = 1'b1;
        apply_reset();
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if (bus.state !== 3'd3 || bus.data_stb_o !== 1'b1 || bus.data_we_o !== 1'b0 ||
                bus.port_stb_o !== 1'b0) begin
                n_fail++; $display("FAIL ldm_wait[%0d]: got st %0d stb %b we %b pstb %b want 3 1 0 0",
                                    i, bus.state, bus.data_stb_o, bus.data_we_o, bus.port_stb_o);
            end
        end
        bus.data_ack_i = 1'b1;
        tick();
        n_tests++;
        if (bus.state !== 3'd4 || bus.reg_we_o !== 1'b1 || bus.data_stb_o !== 1'b0) begin
            n_fail++; $display("FAIL ldm_wb: got st %0d we %b stb %b want 4 1 0",
                                bus.state, bus.reg_we_o, bus.data_stb_o);
        end
        bus.data_ack_i = 1'b0;
        tick();
        n_tests++;
        if (bus.state !== 3'd0 || bus.bus_err_o !== 1'b0) begin
            n_fail++; $display("FAIL ldm_done: got st %0d err %b want 0 0", bus.state, bus.bus_err_o);
        end
        bus.port_ack_i = 1'b0;
    endtask

    task automatic test_timeout();
        bus_to.IR = IR_LDM; bus_to.inst_ack_i = 1'b1; bus_to.data_ack_i = 1'b0;
        bus_to.port_ack_i = 1'b0;
        apply_reset();
        tick();
        repeat (4) tick();
        n_tests++;
        if (bus_to.state !== 3'd3 || bus_to.bus_err_o !== 1'b0) begin
            n_fail++; $display("FAIL mem_before_limit: got st %0d err %b want 3 0",
                                bus_to.state, bus_to.bus_err_o);
        end
        tick();
        n_tests++;
        if (bus_to.state !== 3'd7 || bus_to.bus_err_o !== 1'b1 || bus_to.data_stb_o !== 1'b0) begin
            n_fail++; $display("FAIL mem_halt: got st %0d err %b stb %b want 7 1 0",
                                bus_to.state, bus_to.bus_err_o, bus_to.data_stb_o);
        end
        bus_to.data_ack_i = 1'b1;
        tick();
        tick();
        n_tests++;
        if (bus_to.state !== 3'd7 || bus_to.bus_err_o !== 1'b1) begin
            n_fail++; $display("FAIL halt_sticky: got st %0d err %b want 7 1",
                                bus_to.state, bus_to.bus_err_o);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus_to.state !== 3'd0 || bus_to.bus_err_o !== 1'b0) begin
            n_fail++; $display("FAIL halt_reset: got st %0d err %b want 0 0",
                                bus_to.state, bus_to.bus_err_o);
        end
        // Fetch ack landing exactly on the limit cycle must win over the halt.
        bus_to.inst_ack_i = 1'b0;
        apply_reset();
        repeat (3) tick();
        bus_to.inst_ack_i = 1'b1;
        tick();
        n_tests++;
        if (bus_to.state !== 3'd1 || bus_to.bus_err_o !== 1'b0) begin
            n_fail++; $display("FAIL fetch_ack_at_limit: got st %0d err %b want 1 0",
                                bus_to.state, bus_to.bus_err_o);
        end
        bus_to.inst_ack_i = 1'b0;
        apply_reset();
        repeat (3) tick();
        n_tests++;
        if (bus_to.state !== 3'd0) begin
            n_fail++; $display("FAIL fetch_before_limit: got %0d want 0", bus_to.state);
        end
        tick();
        n_tests++;
        if (bus_to.state !== 3'd7 || bus_to.bus_err_o !== 1'b1) begin
            n_fail++; $display("FAIL fetch_halt: got st %0d err %b want 7 1",
                                bus_to.state, bus_to.bus_err_o);
        end
        bus_to.inst_ack_i = 1'b1;
    endtask

    task automatic test_interrupt();
        bus.IR = IR_ENAI; bus.inst_ack_i = 1'b1; bus.int_req_i = 4'b0000;
        apply_reset();
        repeat (3) tick();
        n_tests++;
        if (bus.state !== 3'd0 || bus.int_en_o !== 1'b1) begin
            n_fail++; $display("FAIL enai: got st %0d en %b want 0 1", bus.state, bus.int_en_o);
        end
        bus.IR = IR_ALU; bus.int_req_i = 4'b0110;
        repeat (3) tick();
        n_tests++;
        if (bus.state !== 3'd4 || bus.int_ack_o !== 1'b0) begin
            n_fail++; $display("FAIL int_pre_wb: got st %0d ack %b want 4 0",
                                bus.state, bus.int_ack_o);
        end
        tick();
        n_tests++;
        if (bus.state !== 3'd5 || bus.int_ack_o !== 1'b1 || bus.int_vec_o !== 2'd1 ||
            bus.int_en_o !== 1'b0) begin
            n_fail++; $display("FAIL int_entry: got st %0d ack %b vec %0d en %b want 5 1 1 0",
                                bus.state, bus.int_ack_o, bus.int_vec_o, bus.int_en_o);
        end
        bus.int_req_i = 4'b0001;
        tick();
        n_tests++;
        if (bus.state !== 3'd0 || bus.int_ack_o !== 1'b0 || bus.int_vec_o !== 2'd1) begin
            n_fail++; $display("FAIL int_exit: got st %0d ack %b vec %0d want 0 0 1",
                                bus.state, bus.int_ack_o, bus.int_vec_o);
        end
        bus.int_req_i = 4'b0000; bus.IR = IR_RETI;
        repeat (3) tick();
        n_tests++;
        if (bus.state !== 3'd0 || bus.int_en_o !== 1'b1) begin
            n_fail++; $display("FAIL reti: got st %0d en %b want 0 1", bus.state, bus.int_en_o);
        end
        bus.IR = IR_DISI;
        repeat (3) tick();
        n_tests++;
        if (bus.int_en_o !== 1'b0) begin
            n_fail++; $display("FAIL disi: got en %b want 0", bus.int_en_o);
        end
        bus.IR = IR_ALU; bus.int_req_i = 4'b0001;
        repeat (4) tick();
        n_tests++;
        if (bus.state !== 3'd0 || bus.int_ack_o !== 1'b0) begin
            n_fail++; $display("FAIL masked_req: got st %0d ack %b want 0 0",
                                bus.state, bus.int_ack_o);
        end
        bus.int_req_i = 4'b0000;
    endtask

    task automatic test_sleep();
        int acks;
        acks = 0;
        bus.IR = IR_WAIT; bus.inst_ack_i = 1'b1; bus.int_req_i = 4'b0000;
        apply_reset();
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            if (bus.int_ack_o === 1'b1) acks++;
            n_tests++;
            if (bus.state !== 3'd6 || bus.inst_stb_o !== 1'b0) begin
                n_fail++; $display("FAIL sleep_hold[%0d]: got st %0d stb %b want 6 0",
                                    i, bus.state, bus.inst_stb_o);
            end
            tick();
        end
        bus.int_req_i = 4'b1000;
        tick();
        if (bus.int_ack_o === 1'b1) acks++;
        n_tests++;
        if (bus.state !== 3'd0 || acks != 0) begin
            n_fail++; $display("FAIL sleep_wake_masked: got st %0d acks %0d want 0 0",
                                bus.state, acks);
        end
        bus.int_req_i = 4'b0000; bus.IR = IR_ENAI;
        repeat (3) tick();
        bus.IR = IR_STBY;
        repeat (3) tick();
        n_tests++;
        if (bus.state !== 3'd6 || bus.int_en_o !== 1'b1) begin
            n_fail++; $display("FAIL stby_sleep: got st %0d en %b want 6 1",
                                bus.state, bus.int_en_o);
        end
        bus.int_req_i = 4'b1000;
        tick();
        n_tests++;
        if (bus.state !== 3'd5 || bus.int_ack_o !== 1'b1 || bus.int_vec_o !== 2'd3) begin
            n_fail++; $display("FAIL stby_wake_int: got st %0d ack %b vec %0d want 5 1 3",
                                bus.state, bus.int_ack_o, bus.int_vec_o);
        end
        bus.int_req_i = 4'b0000;
        tick();
    endtask

    task automatic test_io();
        bus.IR = IR_OUT; bus.inst_ack_i = 1'b1; bus.port_ack_i = 1'b1; bus.data_ack_i = 1'b0;
        apply_reset();
        tick();
        tick();
        n_tests++;
        if (bus.state !== 3'd3 || bus.port_stb_o !== 1'b1 || bus.port_we_o !== 1'b1 ||
            bus.data_stb_o !== 1'b0 || bus.reg_we_o !== 1'b0) begin
            n_fail++; $display("FAIL out_mem: got st %0d pstb %b pwe %b dstb %b we %b want 3 1 1 0 0",
                                bus.state, bus.port_stb_o, bus.port_we_o, bus.data_stb_o,
                                bus.reg_we_o);
        end
        tick();
        n_tests++;
        if (bus.state !== 3'd0 || bus.port_stb_o !== 1'b0 || bus.reg_we_o !== 1'b0) begin
            n_fail++; $display("FAIL out_done: got st %0d pstb %b we %b want 0 0 0",
                                bus.state, bus.port_stb_o, bus.reg_we_o);
        end
        bus.IR = IR_STM; bus.port_ack_i = 1'b0; bus.data_ack_i = 1'b1;
        tick();
        tick();
        n_tests++;
        if (bus.state !== 3'd3 || bus.data_stb_o !== 1'b1 || bus.data_we_o !== 1'b1 ||
            bus.port_stb_o !== 1'b0) begin
            n_fail++; $display("FAIL stm_mem: got st %0d dstb %b dwe %b pstb %b want 3 1 1 0",
                                bus.state, bus.data_stb_o, bus.data_we_o, bus.port_stb_o);
        end
        tick();
        n_tests++;
        if (bus.state !== 3'd0) begin
            n_fail++; $display("FAIL stm_done: got %0d want 0", bus.state);
        end
        bus.IR = IR_INP; bus.port_ack_i = 1'b1; bus.data_ack_i = 1'b0;
        tick();
        tick();
        n_tests++;
        if (bus.state !== 3'd3 || bus.port_stb_o !== 1'b1 || bus.port_we_o !== 1'b0) begin
            n_fail++; $display("FAIL inp_mem: got st %0d pstb %b pwe %b want 3 1 0",
                                bus.state, bus.port_stb_o, bus.port_we_o);
        end
        tick();
        n_tests++;
        if (bus.state !== 3'd4 || bus.reg_we_o !== 1'b1) begin
            n_fail++; $display("FAIL inp_wb: got st %0d we %b want 4 1", bus.state, bus.reg_we_o);
        end
        bus.port_ack_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_mem_wait();
        test_timeout();
        test_interrupt();
        test_sleep();
        test_io();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
